// File: rtl/usb_rx_pkg.sv
// Shared constants and enums for the USB receive-path field assembler.
package usb_rx_pkg;

    localparam int SYNC_W        = 8;
    localparam int PID_W         = 8;
    localparam int CRC5_W        = 5;
    localparam int CRC16_W       = 16;
    localparam int STUFF_RUN_DEF = 6;

    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 8'b1000_0000;

    typedef enum logic [2:0] {
        FLD_NONE,
        FLD_SYNC,
        FLD_PID,
        FLD_CRC5,
        FLD_CRC16,
        FLD_DATA
    } field_t;

    typedef enum logic {
        ST_COUNT,
        ST_STUFF
    } stuff_state_t;

endpackage

// File: rtl/rx_field_sr.sv
// One receive field: LSB-first shift register, accepted-bit counter,
// full flag and a registered one-cycle completion pulse.
module rx_field_sr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         sel,
    input  logic         bit_ok,
    input  logic         clr_cnt,
    input  logic         d,
    output logic         shift_en,
    output logic [W-1:0] value,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sr_q, sr_d, sr_shift;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          done_q, done_d;

    generate
        if (W == 1) begin : g_w1
            assign sr_shift = d;
        end else begin : g_wn
            assign sr_shift = {d, sr_q[W-1:1]};
        end
    endgenerate

    assign shift_en = sel & bit_ok & ~full_q;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        done_d = 1'b0;
        if (!sel) begin
            // Deselection (including idle) restarts the field; the value is kept.
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (shift_en) begin
            sr_d = sr_shift;
            if (cnt_q == CW'(W - 1)) begin
                cnt_d  = CW'(W);
                full_d = 1'b1;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            done_q <= done_d;
        end
    end

    assign value = sr_q;
    assign done  = done_q;

endmodule

// File: rtl/rx_field_shifter.sv
// Receive field assembler: destuffs decoded bits and steers them into the
// field register selected by the receiver control unit.
//   state    | meaning
//   ST_COUNT | counting consecutive accepted 1s
//   ST_STUFF | next strobed bit is a stuff bit, discarded
module rx_field_shifter
    import usb_rx_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int STUFF_RUN = STUFF_RUN_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               shift_enable,
    input  logic               d_orig,
    input  logic               eop,
    input  logic               sync_rcving,
    input  logic               pid_rcving,
    input  logic               crc5_rcving,
    input  logic               crc16_rcving,
    input  logic               data_rcving,
    output logic               sync_shift_enable,
    output logic               pid_shift_enable,
    output logic               crc5_shift_enable,
    output logic               crc16_shift_enable,
    output logic               data_shift_enable,
    output logic [SYNC_W-1:0]  rcv_sync,
    output logic [PID_W-1:0]   rcv_pid,
    output logic [CRC5_W-1:0]  rcv_crc5,
    output logic [CRC16_W-1:0] rcv_crc16,
    output logic [DATA_W-1:0]  rcv_data,
    output logic               sync_bits_received,
    output logic               pid_bits_received,
    output logic               crc5_bits_received,
    output logic               crc16_bits_received,
    output logic               data_bits_received,
    output logic               stuff_error
);

    localparam int OW = $clog2(STUFF_RUN + 1);

    field_t       active;
    stuff_state_t state_q, state_d;
    logic [OW-1:0] ones_q, ones_d;
    logic         stuff_error_q, stuff_error_d;
    logic         bit_ok;
    logic         any_accept;

    always_comb begin
        active = FLD_NONE;
        if (sync_rcving)       active = FLD_SYNC;
        else if (pid_rcving)   active = FLD_PID;
        else if (crc5_rcving)  active = FLD_CRC5;
        else if (crc16_rcving) active = FLD_CRC16;
        else if (data_rcving)  active = FLD_DATA;
    end

    assign bit_ok = shift_enable & (state_q == ST_COUNT) & ~eop;

    rx_field_sr #(.W(SYNC_W)) u_sync (
        .clk(clk), .n_rst(n_rst), .sel(active == FLD_SYNC), .bit_ok(bit_ok),
        .clr_cnt(eop), .d(d_orig), .shift_en(sync_shift_enable),
        .value(rcv_sync), .done(sync_bits_received)
    );

    rx_field_sr #(.W(PID_W)) u_pid (
        .clk(clk), .n_rst(n_rst), .sel(active == FLD_PID), .bit_ok(bit_ok),
        .clr_cnt(eop), .d(d_orig), .shift_en(pid_shift_enable),
        .value(rcv_pid), .done(pid_bits_received)
    );

    rx_field_sr #(.W(CRC5_W)) u_crc5 (
        .clk(clk), .n_rst(n_rst), .sel(active == FLD_CRC5), .bit_ok(bit_ok),
        .clr_cnt(eop), .d(d_orig), .shift_en(crc5_shift_enable),
        .value(rcv_crc5), .done(crc5_bits_received)
    );

    rx_field_sr #(.W(CRC16_W)) u_crc16 (
        .clk(clk), .n_rst(n_rst), .sel(active == FLD_CRC16), .bit_ok(bit_ok),
        .clr_cnt(eop), .d(d_orig), .shift_en(crc16_shift_enable),
        .value(rcv_crc16), .done(crc16_bits_received)
    );

    rx_field_sr #(.W(DATA_W)) u_data (
        .clk(clk), .n_rst(n_rst), .sel(active == FLD_DATA), .bit_ok(bit_ok),
        .clr_cnt(eop), .d(d_orig), .shift_en(data_shift_enable),
        .value(rcv_data), .done(data_bits_received)
    );

    assign any_accept = sync_shift_enable | pid_shift_enable | crc5_shift_enable
                      | crc16_shift_enable | data_shift_enable;

    always_comb begin
        state_d       = state_q;
        ones_d        = ones_q;
        stuff_error_d = 1'b0;
        if (active == FLD_NONE || eop) begin
            state_d = ST_COUNT;
            ones_d  = '0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (any_accept) begin
                        if (!d_orig) begin
                            ones_d = '0;
                        end else if (ones_q == OW'(STUFF_RUN - 1)) begin
                            state_d = ST_STUFF;
                            ones_d  = '0;
                        end else begin
                            ones_d = ones_q + OW'(1);
                        end
                    end
                end
                ST_STUFF: begin
                    if (shift_enable) begin
                        state_d       = ST_COUNT;
                        ones_d        = '0;
                        stuff_error_d = d_orig;
                    end
                end
                default: begin
                    state_d = ST_COUNT;
                    ones_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_COUNT;
            ones_q        <= '0;
            stuff_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ones_q        <= ones_d;
            stuff_error_q <= stuff_error_d;
        end
    end

    assign stuff_error = stuff_error_q;

endmodule

// File: tb/tb_rx_field_shifter.sv
// Self-checking bench for rx_field_shifter: per-cycle scoreboard against a
// behavioural model plus a table of whole-field cases with hand-derived values.
module tb_rx_field_shifter;
    import usb_rx_pkg::*;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic n_rst;
    logic shift_enable, d_orig, eop;
    logic sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving;
    logic sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable, data_shift_enable;
    logic [7:0]    rcv_sync, rcv_pid;
    logic [4:0]    rcv_crc5;
    logic [15:0]   rcv_crc16;
    logic [DW-1:0] rcv_data;
    logic sync_bits_received, pid_bits_received, crc5_bits_received, crc16_bits_received, data_bits_received;
    logic stuff_error;

    rx_field_shifter #(.DATA_W(DW), .STUFF_RUN(6)) dut (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .d_orig(d_orig), .eop(eop),
        .sync_rcving(sync_rcving), .pid_rcving(pid_rcving), .crc5_rcving(crc5_rcving),
        .crc16_rcving(crc16_rcving), .data_rcving(data_rcving),
        .sync_shift_enable(sync_shift_enable), .pid_shift_enable(pid_shift_enable),
        .crc5_shift_enable(crc5_shift_enable), .crc16_shift_enable(crc16_shift_enable),
        .data_shift_enable(data_shift_enable),
        .rcv_sync(rcv_sync), .rcv_pid(rcv_pid), .rcv_crc5(rcv_crc5), .rcv_crc16(rcv_crc16),
        .rcv_data(rcv_data),
        .sync_bits_received(sync_bits_received), .pid_bits_received(pid_bits_received),
        .crc5_bits_received(crc5_bits_received), .crc16_bits_received(crc16_bits_received),
        .data_bits_received(data_bits_received), .stuff_error(stuff_error)
    );

    always #5 clk = ~clk;

    logic [4:0] dut_se, dut_br;
    assign dut_se = {data_shift_enable, crc16_shift_enable, crc5_shift_enable, pid_shift_enable, sync_shift_enable};
    assign dut_br = {data_bits_received, crc16_bits_received, crc5_bits_received, pid_bits_received, sync_bits_received};

    typedef struct {
        logic [4:0]  br;
        logic        serr;
        logic [7:0]  sync_v;
        logic [7:0]  pid_v;
        logic [4:0]  crc5_v;
        logic [15:0] crc16_v;
        logic [63:0] data_v;
    } exp_t;

    typedef struct {
        int           fld;
        int           nbits;
        logic [127:0] raw;
        logic [63:0]  exp_val;
        int           exp_acc;
        int           exp_pulse;
        int           exp_serr;
        string        name;
    } case_t;

    exp_t sb[$];
    case_t cases[7];

    int n_checks = 0;
    int n_fail   = 0;
    int se_cnt[5];
    int br_cnt[5];
    int serr_cnt;

    // Reference model state
    int          wid[5] = '{8, 8, 5, 16, DW};
    logic [63:0] m_reg[5];
    int          m_cnt[5];
    bit          m_full[5];
    bit          m_stuff;
    int          m_ones;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 5; i++) begin
            m_reg[i] = '0; m_cnt[i] = 0; m_full[i] = 0;
        end
        m_stuff = 0; m_ones = 0;
    endfunction

    function automatic void clr_counts();
        for (int i = 0; i < 5; i++) begin
            se_cnt[i] = 0; br_cnt[i] = 0;
        end
        serr_cnt = 0;
    endfunction

    function automatic logic [63:0] field_val(input int f);
        case (f)
            0: return 64'(rcv_sync);
            1: return 64'(rcv_pid);
            2: return 64'(rcv_crc5);
            3: return 64'(rcv_crc16);
            default: return rcv_data;
        endcase
    endfunction

    task automatic cyc(input logic [4:0] sel, input logic se, input logic d, input logic e);
        int         act;
        logic [4:0] exp_se;
        exp_t       ex, got;
        @(negedge clk);
        {data_rcving, crc16_rcving, crc5_rcving, pid_rcving, sync_rcving} = sel;
        shift_enable = se; d_orig = d; eop = e;
        act = -1;
        for (int i = 4; i >= 0; i--) if (sel[i]) act = i;
        for (int i = 0; i < 5; i++)
            exp_se[i] = se && (act == i) && !m_stuff && !m_full[i] && !e;
        #1;
        chk("shift_enable", 64'(dut_se), 64'(exp_se));
        for (int i = 0; i < 5; i++) se_cnt[i] += int'(dut_se[i]);

        ex.br = '0; ex.serr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i != act) begin
                m_cnt[i] = 0; m_full[i] = 0;
            end else if (exp_se[i]) begin
                m_reg[i] = (m_reg[i] >> 1) | (64'(d) << (wid[i] - 1));
                m_cnt[i]++;
                if (m_cnt[i] == wid[i]) begin
                    ex.br[i] = 1'b1; m_full[i] = 1;
                end
            end else if (e) begin
                m_cnt[i] = 0;
            end
        end
        if (act < 0 || e) begin
            m_stuff = 0; m_ones = 0;
        end else if (m_stuff) begin
            if (se) begin
                ex.serr = d; m_stuff = 0; m_ones = 0;
            end
        end else if (|exp_se) begin
            if (d) begin
                m_ones++;
                if (m_ones == 6) begin
                    m_stuff = 1; m_ones = 0;
                end
            end else begin
                m_ones = 0;
            end
        end
        ex.sync_v = m_reg[0][7:0]; ex.pid_v = m_reg[1][7:0]; ex.crc5_v = m_reg[2][4:0];
        ex.crc16_v = m_reg[3][15:0]; ex.data_v = m_reg[4];
        sb.push_back(ex);

        @(posedge clk);
        #1;
        chk("scoreboard_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("bits_received", 64'(dut_br), 64'(got.br));
            chk("stuff_error", 64'(stuff_error), 64'(got.serr));
            chk("rcv_sync", 64'(rcv_sync), 64'(got.sync_v));
            chk("rcv_pid", 64'(rcv_pid), 64'(got.pid_v));
            chk("rcv_crc5", 64'(rcv_crc5), 64'(got.crc5_v));
            chk("rcv_crc16", 64'(rcv_crc16), 64'(got.crc16_v));
            chk("rcv_data", rcv_data, got.data_v);
        end
        for (int i = 0; i < 5; i++) br_cnt[i] += int'(dut_br[i]);
        serr_cnt += int'(stuff_error);
    endtask

    task automatic idle();
        cyc(5'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rcv_sync"}, 64'(rcv_sync), 64'd0);
        chk({tag, "_rcv_pid"}, 64'(rcv_pid), 64'd0);
        chk({tag, "_rcv_crc5"}, 64'(rcv_crc5), 64'd0);
        chk({tag, "_rcv_crc16"}, 64'(rcv_crc16), 64'd0);
        chk({tag, "_rcv_data"}, rcv_data, 64'd0);
        chk({tag, "_bits_received"}, 64'(dut_br), 64'd0);
        chk({tag, "_stuff_error"}, 64'(stuff_error), 64'd0);
    endtask

    initial begin
        cases[0] = '{0,  8, 128'h80,                   64'h80,                  8, 1, 0, "sync"};
        cases[1] = '{1,  9, 128'h0C3,                  64'hC3,                  8, 1, 0, "pid_extra_bit"};
        cases[2] = '{2,  5, 128'h0D,                   64'h0D,                  5, 1, 0, "crc5"};
        cases[3] = '{3, 17, 128'h1553F,                64'hAABF,               16, 1, 0, "crc16_stuff"};
        cases[4] = '{4, 65, 128'h1_0000_0000_0000_003F, 64'h8000_0000_0000_003F, 64, 1, 0, "data_stuff"};
        cases[5] = '{1,  9, 128'h17F,                  64'hBF,                  8, 1, 1, "stuff_error"};
        cases[6] = '{1,  9, 128'h17E,                  64'hFE,                  8, 1, 0, "stuff_last_bit"};

        n_rst = 1'b0;
        shift_enable = 0; d_orig = 0; eop = 0;
        {data_rcving, crc16_rcving, crc5_rcving, pid_rcving, sync_rcving} = 5'b0;
        m_reset();
        clr_counts();
        #12;
        chk_all_zero("reset");
        chk("reset_shift_enable", 64'(dut_se), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        idle();

        for (int c = 0; c < 7; c++) begin
            logic [127:0] raw;
            logic [4:0]   sel;
            raw = cases[c].raw;
            sel = 5'b1 << cases[c].fld;
            clr_counts();
            for (int b = 0; b < cases[c].nbits; b++) cyc(sel, 1'b1, raw[b], 1'b0);
            idle();
            chk({cases[c].name, "_value"}, field_val(cases[c].fld), cases[c].exp_val);
            chk({cases[c].name, "_accepted"}, 64'(se_cnt[cases[c].fld]), 64'(cases[c].exp_acc));
            chk({cases[c].name, "_pulses"}, 64'(br_cnt[cases[c].fld]), 64'(cases[c].exp_pulse));
            chk({cases[c].name, "_stuff_errors"}, 64'(serr_cnt), 64'(cases[c].exp_serr));
        end
        chk("sync_pattern", 64'(rcv_sync), 64'(SYNC_PATTERN));

        // Field change crc5 -> crc16, then eop partway through crc16
        clr_counts();
        cyc(5'b00100, 1, 1, 0);
        cyc(5'b00100, 1, 0, 0);
        cyc(5'b00100, 1, 1, 0);
        cyc(5'b01000, 1, 1, 0);
        cyc(5'b01000, 1, 0, 0);
        cyc(5'b01000, 1, 0, 0);
        cyc(5'b01000, 1, 1, 0);
        cyc(5'b01000, 1, 1, 1);
        for (int b = 0; b < 12; b++) cyc(5'b01000, 1, 1'(b % 2), 0);
        idle();
        chk("crc5_partial", 64'(rcv_crc5), 64'h15);
        chk("crc16_accepted", 64'(se_cnt[3]), 64'd16);
        chk("crc16_no_pulse", 64'(br_cnt[3]), 64'd0);

        // Reset in the middle of a data field
        clr_counts();
        for (int b = 0; b < 20; b++) cyc(5'b10000, 1, 1'(b % 2), 0);
        @(negedge clk);
        shift_enable = 0; d_orig = 0;
        {data_rcving, crc16_rcving, crc5_rcving, pid_rcving, sync_rcving} = 5'b0;
        #2 n_rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        m_reset();
        @(posedge clk);
        #1;
        chk_all_zero("held_reset");
        @(negedge clk);
        n_rst = 1'b1;
        for (int b = 0; b < 64; b++) cyc(5'b10000, 1, 1'(b % 3 == 0), 0);
        idle();
        chk("data_after_reset", rcv_data, 64'h9249_2492_4924_9249);
        chk("data_pulses", 64'(br_cnt[4]), 64'd1);
        chk("data_accepted", 64'(se_cnt[4]), 64'd84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
